// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master side requests conversions; the slave side is the converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 14
);
  logic                 start;
  logic [BIN_WIDTH-1:0] bin;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic [3:0]           digit1;
  logic [3:0]           digit2;
  logic [3:0]           digit3;
  logic [3:0]           digit4;

  modport master (
    output start, bin,
    input  busy, done, ovf, digit1, digit2, digit3, digit4
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, digit1, digit2, digit3, digit4
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD converter, one input bit per clock.
// Digits only change on the done cycle so a multiplexed display never shows partial results.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14
) (
  input  logic            clk,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus
);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [BIN_WIDTH-1:0] shift_d;
  logic [15:0]          scratch_q;
  logic [15:0]          scratch_adj;
  logic [15:0]          scratch_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_pend_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;
  logic [3:0]           digit_q [4];
  logic                 start_ovf;

  // Add-3 correction on every nibble, all taken from the pre-shift scratch value.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                  ? scratch_q[gi*4 +: 4] + 4'd3
                                  : scratch_q[gi*4 +: 4];
  end

  assign scratch_d = {scratch_adj[14:0], shift_q[BIN_WIDTH-1]};
  assign shift_d   = {shift_q[BIN_WIDTH-2:0], 1'b0};

  // Only a 14-bit input can exceed four decimal digits; narrower widths fold to 0.
  assign start_ovf = (32'(bus.bin) > 32'd9999);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= 4'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            shift_q    <= bus.bin;
            scratch_q  <= '0;
            cnt_q      <= CNT_W'(BIN_WIDTH);
            ovf_pend_q <= start_ovf;
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - 1'b1;
          // Last shift: publish the finished result so it is visible during DONE.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            ovf_q   <= ovf_pend_q;
            for (int i = 0; i < 4; i++) begin
              digit_q[i] <= ovf_pend_q ? 4'd9 : scratch_d[i*4 +: 4];
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
  assign bus.digit1 = digit_q[0];
  assign bus.digit2 = digit_q[1];
  assign bus.digit3 = digit_q[2];
  assign bus.digit4 = digit_q[3];
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and strided-sweep checks of bin_to_bcd_seq: timing, hold, overflow clamp, ignored starts, reset abort.
module tb_bin_to_bcd_seq;
  localparam int BW = 14;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] dig;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [15:0] prev_dig;
  logic        prev_ovf;
  logic [15:0] dig_w;
  vec_t        vecs [11];

  bin_to_bcd_seq_if #(.BIN_WIDTH(BW)) bif ();

  bin_to_bcd_seq #(.BIN_WIDTH(BW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bif.slave)
  );

  assign dig_w = {bif.digit4, bif.digit3, bif.digit2, bif.digit1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic bit nib_ok(input logic [15:0] d);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (d[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Called at a negedge; start is sampled at the next posedge (edge N).
  task automatic run_conv(input logic [13:0] b, input logic [15:0] exp_dig,
                          input logic exp_ovf, input string tag);
    int done_cnt;
    int done_k;
    int busy_err;
    int hold_err;
    done_cnt = 0;
    done_k   = 0;
    busy_err = 0;
    hold_err = 0;
    bif.start = 1'b1;
    bif.bin   = b;
    for (int k = 1; k <= BW + 3; k++) begin
      @(negedge clk);
      if (bif.busy !== ((k <= BW + 1) ? 1'b1 : 1'b0)) busy_err++;
      if (bif.done === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
      if (k <= BW && (dig_w !== prev_dig || bif.ovf !== prev_ovf)) hold_err++;
      if (k == BW + 1) begin
        chk({tag, " digits"}, int'(dig_w), int'(exp_dig));
        chk({tag, " ovf"}, int'(bif.ovf), int'(exp_ovf));
        chk({tag, " nibble<=9"}, int'(nib_ok(dig_w)), 1);
      end
      if (k == 1) bif.start = 1'b0;
      if (k == 2) bif.bin = ~b;
    end
    chk({tag, " busy window errors"}, busy_err, 0);
    chk({tag, " hold errors"}, hold_err, 0);
    chk({tag, " done count"}, done_cnt, 1);
    chk({tag, " done cycle"}, done_k, BW + 1);
    $display("conv bin=%0d -> %0h ovf=%0b (expected %0h ovf=%0b)",
             b, dig_w, bif.ovf, exp_dig, exp_ovf);
    prev_dig = exp_dig;
    prev_ovf = exp_ovf;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    prev_dig  = 16'h0000;
    prev_ovf  = 1'b0;
    bif.start = 1'b0;
    bif.bin   = '0;
    rst       = 1'b1;

    vecs[0]  = '{bin: 14'd0,     dig: 16'h0000, ovf: 1'b0};
    vecs[1]  = '{bin: 14'd1234,  dig: 16'h1234, ovf: 1'b0};
    vecs[2]  = '{bin: 14'd9999,  dig: 16'h9999, ovf: 1'b0};
    vecs[3]  = '{bin: 14'd10,    dig: 16'h0010, ovf: 1'b0};
    vecs[4]  = '{bin: 14'd10000, dig: 16'h9999, ovf: 1'b1};
    vecs[5]  = '{bin: 14'd16383, dig: 16'h9999, ovf: 1'b1};
    vecs[6]  = '{bin: 14'd5,     dig: 16'h0005, ovf: 1'b0};
    vecs[7]  = '{bin: 14'd100,   dig: 16'h0100, ovf: 1'b0};
    vecs[8]  = '{bin: 14'd4095,  dig: 16'h4095, ovf: 1'b0};
    vecs[9]  = '{bin: 14'd8191,  dig: 16'h8191, ovf: 1'b0};
    vecs[10] = '{bin: 14'd9,     dig: 16'h0009, ovf: 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", int'(bif.busy), 0);
    chk("reset done", int'(bif.done), 0);
    chk("reset ovf", int'(bif.ovf), 0);
    chk("reset digits", int'(dig_w), 0);

    for (int i = 0; i < 11; i++) begin
      run_conv(vecs[i].bin, vecs[i].dig, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Starts during SHIFT and during DONE are dropped; the next IDLE start is taken.
    begin
      int extra_done;
      extra_done = 0;
      bif.start = 1'b1;
      bif.bin   = 14'd42;
      for (int k = 1; k <= 33; k++) begin
        @(negedge clk);
        if (k == 15) begin
          chk("ign done@15", int'(bif.done), 1);
          chk("ign digits@15", int'(dig_w), 16'h0042);
        end else if (k == 31) begin
          chk("ign done@31", int'(bif.done), 1);
          chk("ign digits@31", int'(dig_w), 16'h0007);
        end else if (bif.done === 1'b1) begin
          extra_done++;
        end
        if (k == 16) chk("ign busy@16", int'(bif.busy), 0);
        if (k == 17) chk("ign busy@17", int'(bif.busy), 1);
        if (k == 30) chk("ign hold@30", int'(dig_w), 16'h0042);
        bif.start = (k == 3 || k == 15 || k == 16);
        bif.bin   = (k >= 3) ? 14'd7 : 14'd42;
      end
      bif.start = 1'b0;
      chk("ign extra dones", extra_done, 0);
      $display("ignored-start sequence: digits=%0h", dig_w);
      prev_dig = 16'h0007;
      prev_ovf = 1'b0;
    end

    // Reset mid-conversion aborts with no done and clears the outputs.
    run_conv(14'd10000, 16'h9999, 1'b1, "pre-abort");
    begin
      int early_done;
      early_done = 0;
      bif.start = 1'b1;
      bif.bin   = 14'd777;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (bif.done === 1'b1) early_done++;
        if (k == 6) chk("abort hold@6", int'(dig_w), 16'h9999);
        if (k == 7) begin
          chk("abort busy", int'(bif.busy), 0);
          chk("abort ovf", int'(bif.ovf), 0);
          chk("abort digits", int'(dig_w), 0);
        end
        bif.start = 1'b0;
        rst = (k == 6);
      end
      chk("abort dones", early_done, 0);
      $display("reset-abort sequence: digits=%0h ovf=%0b", dig_w, bif.ovf);
      prev_dig = 16'h0000;
      prev_ovf = 1'b0;
    end
    run_conv(14'd777, 16'h0777, 1'b0, "post-abort");

    // Strided sweep plus the overflow boundary values.
    for (int v = 0; v < 16384; v += 97) begin
      run_conv(14'(v), model_bcd(v), (v > 9999), $sformatf("sweep%0d", v));
    end
    for (int v = 9998; v <= 10001; v++) begin
      run_conv(14'(v), model_bcd(v), (v > 9999), $sformatf("edge%0d", v));
    end
    run_conv(14'd16383, model_bcd(16383), 1'b1, "edge16383");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
